// File: rtl/nibble_serial_branch_comp_if.sv
// Handshake bundle for the digit-serial branch comparator:
// operand/funct3 request side plus registered result side.
interface nibble_serial_branch_comp_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic [2:0]       funct3;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             lt;
  logic             gt;
  logic             taken;
  logic             illegal;

  modport master (
    output in_valid, rs1, rs2, funct3, out_ready,
    input  in_ready, out_valid, eq, lt, gt, taken, illegal
  );

  modport slave (
    input  in_valid, rs1, rs2, funct3, out_ready,
    output in_ready, out_valid, eq, lt, gt, taken, illegal
  );
endinterface

// File: rtl/nibble_serial_branch_comp.sv
// RV32I branch comparator evaluated one DIGIT-bit slice per clock,
// LSB-first, with a running eq/lt/gt cascade between slices.
module nibble_serial_branch_comp #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic clk,
  input logic rst,
  nibble_serial_branch_comp_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a, b;
  logic [2:0]       f3;
  logic [CW-1:0]    cnt;
  logic             c_eq, c_lt, c_gt;
  logic [DIGIT-1:0] da, db;
  logic             n_eq, n_lt, n_gt;
  logic             n_taken, n_illegal;
  logic             sgn;
  logic             r_valid, r_eq, r_lt, r_gt;
  logic             r_taken, r_illegal;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = r_valid;
  assign bus.eq        = r_eq;
  assign bus.lt        = r_lt;
  assign bus.gt        = r_gt;
  assign bus.taken     = r_taken;
  assign bus.illegal   = r_illegal;

  // Flipping the sign bits turns a signed compare into an unsigned one
  assign sgn = (bus.funct3[2:1] == 2'b10);
  assign da  = a[DIGIT-1:0];
  assign db  = b[DIGIT-1:0];

  always_comb begin
    n_eq = c_eq;
    n_lt = c_lt;
    n_gt = c_gt;
    if (da > db) begin
      n_gt = 1'b1;
      n_lt = 1'b0;
      n_eq = 1'b0;
    end else if (da < db) begin
      n_gt = 1'b0;
      n_lt = 1'b1;
      n_eq = 1'b0;
    end
  end

  always_comb begin
    n_taken   = 1'b0;
    n_illegal = 1'b0;
    unique case (f3)
      3'b000:         n_taken = n_eq;
      3'b001:         n_taken = !n_eq;
      3'b100, 3'b110: n_taken = n_lt;
      3'b101, 3'b111: n_taken = !n_lt;
      default:        n_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      f3        <= '0;
      cnt       <= '0;
      c_eq      <= 1'b1;
      c_lt      <= 1'b0;
      c_gt      <= 1'b0;
      r_valid   <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
      r_gt      <= 1'b0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            f3    <= bus.funct3;
            a     <= sgn ? (bus.rs1 ^ MSB) : bus.rs1;
            b     <= sgn ? (bus.rs2 ^ MSB) : bus.rs2;
            c_eq  <= 1'b1;
            c_lt  <= 1'b0;
            c_gt  <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          c_eq <= n_eq;
          c_lt <= n_lt;
          c_gt <= n_gt;
          a    <= a >> DIGIT;
          b    <= b >> DIGIT;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            r_eq      <= n_eq;
            r_lt      <= n_lt;
            r_gt      <= n_gt;
            r_taken   <= n_taken;
            r_illegal <= n_illegal;
            r_valid   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_branch_comp.sv
// Directed vector bench for nibble_serial_branch_comp: result table,
// latency, backpressure and mid-operation reset sequences.
module tb_nibble_serial_branch_comp;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  nibble_serial_branch_comp_if #(.WIDTH(32)) bus ();

  nibble_serial_branch_comp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic        eq;
    logic        lt;
    logic        gt;
    logic        taken;
    logic        illegal;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [2:0] f,
                         input logic [4:0] res);
    vecs[i].rs1     = r1;
    vecs[i].rs2     = r2;
    vecs[i].f3      = f;
    vecs[i].eq      = res[4];
    vecs[i].lt      = res[3];
    vecs[i].gt      = res[2];
    vecs[i].taken   = res[1];
    vecs[i].illegal = res[0];
  endtask

  // Issue one op; stays on a negedge with out_valid high on return
  task automatic start_op(input vec_t v, input string tag);
    int lat;
    logic busy_bad;
    @(negedge clk);
    chk({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.rs1      = v.rs1;
    bus.rs2      = v.rs2;
    bus.funct3   = v.f3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.rs1      = 32'hDEAD_BEEF;
    bus.rs2      = 32'h0BAD_F00D;
    bus.funct3   = 3'b010;
    lat = 0;
    busy_bad = 1'b0;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready) busy_bad = 1'b1;
      bus.in_valid = (lat % 2 == 1);
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'd8);
    chk({tag, " in_ready busy"}, 32'(busy_bad), 32'd0);
  endtask

  task automatic check_res(input vec_t v, input string tag);
    chk({tag, " eq"}, 32'(bus.eq), 32'(v.eq));
    chk({tag, " lt"}, 32'(bus.lt), 32'(v.lt));
    chk({tag, " gt"}, 32'(bus.gt), 32'(v.gt));
    chk({tag, " taken"}, 32'(bus.taken), 32'(v.taken));
    chk({tag, " illegal"}, 32'(bus.illegal), 32'(v.illegal));
  endtask

  task automatic finish_op(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " out_valid clr"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " in_ready back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.funct3    = '0;

    // res bits: {eq, lt, gt, taken, illegal}
    set_vec(0,  32'h12345678, 32'h12345678, 3'b000, 5'b10010);
    set_vec(1,  32'hFFFFFFFF, 32'h00000001, 3'b100, 5'b01010);
    set_vec(2,  32'hFFFFFFFF, 32'h00000001, 3'b110, 5'b00100);
    set_vec(3,  32'hFFFFFFFF, 32'h00000001, 3'b101, 5'b01000);
    set_vec(4,  32'h00000010, 32'h00000011, 3'b111, 5'b01000);
    set_vec(5,  32'h80000000, 32'h7FFFFFFF, 3'b101, 5'b01000);
    set_vec(6,  32'h00000005, 32'h00000003, 3'b010, 5'b00101);
    set_vec(7,  32'h00000001, 32'h00000002, 3'b001, 5'b01010);
    set_vec(8,  32'h00000007, 32'h00000007, 3'b111, 5'b10010);
    set_vec(9,  32'h80000000, 32'h00000001, 3'b110, 5'b00100);
    set_vec(10, 32'h00000003, 32'h00000009, 3'b011, 5'b01001);
    set_vec(11, 32'hA0000000, 32'hA0000001, 3'b100, 5'b01010);

    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst results",
        32'({bus.eq, bus.lt, bus.gt, bus.taken, bus.illegal}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_op(vecs[i], tag);
      check_res(vecs[i], tag);
      finish_op(tag);
    end

    // Backpressure: results and flags frozen while out_ready is low
    begin
      logic [4:0] snap;
      logic       moved;
      start_op(vecs[0], "bp");
      snap  = {bus.eq, bus.lt, bus.gt, bus.taken, bus.illegal};
      moved = 1'b0;
      for (int k = 0; k < 5; k++) begin
        bus.in_valid = 1'b1;
        bus.rs1      = 32'h1;
        bus.rs2      = 32'h2;
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (!bus.out_valid || bus.in_ready) moved = 1'b1;
        if ({bus.eq, bus.lt, bus.gt, bus.taken, bus.illegal} != snap)
          moved = 1'b1;
      end
      chk("bp stable", 32'(moved), 32'd0);
      check_res(vecs[0], "bp");
      finish_op("bp");
    end

    // Reset four cycles into RUN, with prior eq/taken still high
    begin
      vec_t bne;
      start_op(vecs[0], "pre");
      finish_op("pre");
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.rs1      = 32'h5;
      bus.rs2      = 32'h5;
      bus.funct3   = 3'b000;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid in_ready", 32'(bus.in_ready), 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("async rst results",
          32'({bus.out_valid, bus.eq, bus.lt, bus.gt, bus.taken,
               bus.illegal}), 32'd0);
      chk("async rst in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("aborted no result", 32'(bus.out_valid), 32'd0);
      chk("abort in_ready", 32'(bus.in_ready), 32'd1);
      bne.rs1 = 32'h1;
      bne.rs2 = 32'h2;
      bne.f3  = 3'b001;
      bne.eq  = 1'b0;
      bne.lt  = 1'b1;
      bne.gt  = 1'b0;
      bne.taken   = 1'b1;
      bne.illegal = 1'b0;
      v = bne;
      start_op(v, "bne");
      check_res(v, "bne");
      finish_op("bne");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
